// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU/NPU core and its job sequencer:
// flag bit positions, mode and opcode encodings, sequencer state encoding.
package alu_pkg;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_E = 0;

  localparam logic MODE_ALU = 1'b0;
  localparam logic MODE_NPU = 1'b1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_MOD = 4'h4;
  localparam logic [3:0] OP_AND = 4'hA;
  localparam logic [3:0] OP_OR  = 4'hB;
  localparam logic [3:0] OP_XOR = 4'hC;
  localparam logic [3:0] OP_NOT = 4'hD;

  localparam logic [3:0] NPU_RELU = 4'h0;
  localparam logic [3:0] NPU_MIN  = 4'h1;
  localparam logic [3:0] NPU_AVG  = 4'h2;
  localparam logic [3:0] NPU_MAX  = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; when both
// request, the one that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one 4-bit ALU/NPU core between two requesters. One job at a time:
// operands are latched on accept, held on the core inputs while the core
// latency elapses, then result/flags are returned tagged with the requester.
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT  = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [7:0]          req_a,
  input  logic [7:0]          req_b,
  input  logic [7:0]          req_op,
  input  logic [1:0]          req_mode,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [3:0]          alu_op,
  output logic                alu_mode,
  input  logic [3:0]          alu_result,
  input  logic [3:0]          alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [3:0]          rsp_result,
  output logic [3:0]          rsp_flags,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             job_id;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             acc_id;
  logic             capture;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Only IDLE offers a grant, so nothing is accepted on the response edge
  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];
  assign capture   = (state == ST_WAIT) && (cnt == '0);
  assign busy      = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> wait out core latency -> hold response until taken
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0)   state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning requester's operands onto the core and arm the latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_mode   <= 1'b0;
      job_id     <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else if (accept) begin
      alu_a      <= req_a[{acc_id, 2'b00} +: 4];
      alu_b      <= req_b[{acc_id, 2'b00} +: 4];
      alu_op     <= req_op[{acc_id, 2'b00} +: 4];
      alu_mode   <= req_mode[acc_id];
      job_id     <= acc_id;
      last_grant <= acc_id;
      cnt        <= CNT_W'(ALU_LAT);
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Capture the core output once the latency has elapsed; release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= job_id;
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Saturating count of jobs that came back with the error flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_count <= '0;
    else if (capture && alu_flags[FLG_E]) err_count <= sat_inc(err_count);
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural 2-edge ALU/NPU core.
module tb_alu_rr_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_a = '0, req_b = '0, req_op = '0;
  logic [1:0] req_mode = '0;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_mode;
  logic [3:0] alu_result, alu_flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [3:0] rsp_result, rsp_flags;
  logic       busy;
  logic [7:0] err_count;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.ALU_LAT(2), .ERRCNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_mode   (req_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy),
    .err_count  (err_count)
  );

  // Behavioural core: {Z,C,S,E,result}
  function automatic logic [7:0] core_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op, input logic mode);
    logic [4:0] s;
    logic [7:0] p;
    logic [3:0] r;
    logic       c, e;
    s = '0; p = '0; r = '0; c = 1'b0; e = 1'b0;
    if (mode == MODE_ALU) begin
      case (op)
        OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
        OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; end
        OP_MUL: begin p = {4'b0, a} * {4'b0, b}; r = p[3:0]; c = |p[7:4]; end
        OP_DIV: if (b == 4'd0) e = 1'b1; else r = a / b;
        OP_MOD: if (b == 4'd0) e = 1'b1; else r = a % b;
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_NOT: r = ~a;
        default: e = 1'b1;
      endcase
    end else begin
      case (op)
        NPU_RELU: r = a[3] ? 4'd0 : a;
        NPU_MIN:  r = (a < b) ? a : b;
        NPU_AVG:  begin s = {1'b0, a} + {1'b0, b}; r = s[4:1]; end
        NPU_MAX:  r = (a > b) ? a : b;
        default:  e = 1'b1;
      endcase
    end
    return {(r == 4'd0), c, r[3], e, r};
  endfunction

  logic [3:0] c_a = '0, c_b = '0, c_op = '0;
  logic       c_mode = 1'b0;
  logic [7:0] c_out = '0;

  // Core model: input register then result register
  always @(posedge clk) begin
    c_a    <= alu_a;
    c_b    <= alu_b;
    c_op   <= alu_op;
    c_mode <= alu_mode;
    c_out  <= core_fn(c_a, c_b, c_op, c_mode);
  end

  assign alu_result = c_out[3:0];
  assign alu_flags  = c_out[7:4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_timeout"}, rsp_valid, 1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, rsp_valid, 0);
  endtask

  // Single-requester job with exact latency checks
  task automatic run_job(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input logic mode,
                         input logic [3:0] er, input logic [3:0] ef, input string tag);
    req_a[id*4 +: 4]  = a;
    req_b[id*4 +: 4]  = b;
    req_op[id*4 +: 4] = op;
    req_mode[id]      = mode;
    req_valid[id]     = 1'b1;
    #1;
    check({tag, "_req_ready"}, req_ready, (id == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    req_valid[id] = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_alu_a"}, alu_a, a);
    check({tag, "_alu_op"}, alu_op, op);
    check({tag, "_lat0"}, rsp_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({tag, "_lat"}, rsp_valid, (k == 3) ? 1 : 0);
    end
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_flags"}, rsp_flags, ef);
    handshake(tag);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int  jobs;
    int  cyc;
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_mode", alu_mode, 0);
    check("rst_err_count", err_count, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Requester 0 ADD, requester 1 divide by zero
    run_job(0, 4'd3, 4'd4, OP_ADD, MODE_ALU, 4'd7, 4'b0000, "r0_add");
    run_job(1, 4'd5, 4'd0, OP_DIV, MODE_ALU, 4'd0, 4'b1001, "r1_div0");
    check("err_after_div0", err_count, 1);

    // Both requesters held valid: strict alternation starting with r0
    req_a = {4'd2, 4'd9};
    req_b = {4'd7, 4'd6};
    req_op = {OP_AND, NPU_MAX};
    req_mode = {MODE_ALU, MODE_NPU};
    req_valid = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_rsp("alt");
      check("alt_id", rsp_id, j % 2);
      check("alt_result", rsp_result, (j % 2 == 0) ? 4'd9 : 4'd2);
      check("alt_flags", rsp_flags, (j % 2 == 0) ? 4'b0010 : 4'b0000);
      rsp_ready = 1'b1;
      if (j == 2) req_valid = 2'b00;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    check("alt_idle", busy, 0);

    // Response back-pressure with r0 still valid; operands sampled only on accept
    req_a = 8'h01;
    req_b = 8'h02;
    req_op = {OP_ADD, OP_ADD};
    req_mode = 2'b00;
    req_valid = 2'b01;
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 3);
      check("bp_flags", rsp_flags, 0);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    req_a[3:0] = 4'd5;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_back_idle", busy, 0);
    check("bp_ready_again", req_ready, 2'b01);
    @(negedge clk);
    check("bp_reaccept", busy, 1);
    check("bp_new_a", alu_a, 5);
    req_a[3:0] = 4'hF;
    req_valid = 2'b00;
    @(negedge clk);
    check("bp_a_held", alu_a, 5);
    wait_rsp("bp2");
    check("bp2_result", rsp_result, 7);
    handshake("bp2");

    // Reset in the middle of a WAIT
    req_a[7:4] = 4'd6;
    req_b[7:4] = 4'd1;
    req_op[7:4] = OP_SUB;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_alu_a", alu_a, 0);
    check("mid_alu_op", alu_op, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("mid_no_rsp", seen, 0);
    req_valid = 2'b11;
    #1;
    check("mid_first_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    run_job(0, 4'd2, 4'd2, OP_MUL, MODE_ALU, 4'd4, 4'b0000, "post_rst_mul");

    // Error counter saturation over 256 divide-by-zero jobs
    req_a[3:0] = 4'd5;
    req_b[3:0] = 4'd0;
    req_op[3:0] = OP_DIV;
    req_mode[0] = MODE_ALU;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    jobs = 0;
    cyc = 0;
    while (jobs < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        jobs++;
        if (jobs == 1)   check("sat_first_flags", rsp_flags, 4'b1001);
        if (jobs == 254) check("sat_254", err_count, 8'hFE);
        if (jobs == 255) check("sat_255", err_count, 8'hFF);
        if (jobs == 256) check("sat_256", err_count, 8'hFF);
      end
    end
    check("sat_jobs_done", jobs, 256);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
